// File: rtl/pipe_advance_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_advance_ctrl_if
//   Bundles the stage-logic <-> pipeline-register handshake of the core.
//
//   Handshake (one rule for every stage i):
//     The stage logic offers stage_valid[i]/stage_data[i] together with
//     stage_ok[i]. The controller answers with stage_adv[i]. A transfer
//     happens at the rising edge where stage_adv[i] = 1. Until then the stage
//     keeps stage_valid[i]/stage_data[i] stable. A stage whose input is a
//     bubble must report stage_ok[i] = 1 so that bubbles never hold the pipe.
//
//   Signals
//     stage_ok     stage i has finished its current work
//     stage_valid  stage i output carries a real instruction
//     stage_data   stage i payload, slice i = [i*DATA_W +: DATA_W]
//     flush_valid  kill younger instructions this cycle
//     flush_upto   regs 0..flush_upto are invalidated (clamped to last reg)
//     reg_valid    valid bit of pipeline reg i
//     reg_data     payload of pipeline reg i
//     stage_adv    reg i loads at the next edge
//     commit_valid valid bit of the last (commit) register
//
//   Modports
//     master  stage logic side (drives stage_*/flush_*)
//     slave   pipe_advance_ctrl side (drives reg_*/stage_adv/commit_valid)
// -----------------------------------------------------------------------------
interface pipe_advance_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int DATA_W     = 64
);
    localparam int FU_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic [NUM_STAGES-1:0]        stage_ok;
    logic [NUM_STAGES-1:0]        stage_valid;
    logic [NUM_STAGES*DATA_W-1:0] stage_data;
    logic                         flush_valid;
    logic [FU_W-1:0]              flush_upto;
    logic [NUM_STAGES-1:0]        reg_valid;
    logic [NUM_STAGES*DATA_W-1:0] reg_data;
    logic [NUM_STAGES-1:0]        stage_adv;
    logic                         commit_valid;

    modport master (
        output stage_ok,
        output stage_valid,
        output stage_data,
        output flush_valid,
        output flush_upto,
        input  reg_valid,
        input  reg_data,
        input  stage_adv,
        input  commit_valid
    );

    modport slave (
        input  stage_ok,
        input  stage_valid,
        input  stage_data,
        input  flush_valid,
        input  flush_upto,
        output reg_valid,
        output reg_data,
        output stage_adv,
        output commit_valid
    );
endinterface

// File: rtl/pipe_advance_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_advance_ctrl
//   Owns the NUM_STAGES inter-stage pipeline registers of the core
//   (IF/ID, ID/EX, EX/MEM, MEM/WB, WB/commit) and decides every cycle whether
//   each register loads, holds, or turns into a bubble. Supports per-stage
//   elastic advance (GLOBAL_STALL = 0) or lockstep advance (GLOBAL_STALL = 1),
//   a ranged flush of the youngest registers, and three perf counters.
//
//   Ports
//     clk         clock, rising edge
//     rst         asynchronous, active-low reset
//     bus         pipe_advance_ctrl_if.slave (stage handshake + register outputs)
//     cnt_cycle   cycles since reset
//     cnt_commit  retired instructions (edges with commit_valid = 1)
//     cnt_stall   edges where at least one stage_ok was 0
//
//   Parameters
//     NUM_STAGES   number of pipeline registers (last one = commit)
//     DATA_W       payload bits per register
//     GLOBAL_STALL 1: lockstep, 0: elastic
//     CNT_W        perf counter width (counters wrap)
// -----------------------------------------------------------------------------
module pipe_advance_ctrl #(
    parameter int NUM_STAGES   = 5,
    parameter int DATA_W       = 64,
    parameter int GLOBAL_STALL = 0,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_advance_ctrl_if.slave   bus,
    output logic [CNT_W-1:0]     cnt_cycle,
    output logic [CNT_W-1:0]     cnt_commit,
    output logic [CNT_W-1:0]     cnt_stall
);
    localparam int FU_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [FU_W-1:0] LAST_IDX = FU_W'(NUM_STAGES - 1);

    // Register state
    logic [NUM_STAGES-1:0]        valid_q;
    logic [NUM_STAGES*DATA_W-1:0] data_q;

    // Per-cycle decisions
    logic [NUM_STAGES-1:0] adv;    // reg i loads at the next edge
    logic [NUM_STAGES-1:0] drain;  // reg i content is taken by the consumer above
    logic [NUM_STAGES-1:0] kill;   // reg i is invalidated by the flush
    logic                  all_ok;
    logic [FU_W-1:0]       flush_lim;

    assign all_ok = &bus.stage_ok;

    // ------------------------------------------------------------------
    // Advance / drain decision.
    // Walked from the commit register down to reg 0: a register can take
    // new data when it is empty or when the stage above consumes it this
    // cycle. The commit register is consumed every cycle, which is what
    // seeds the chain. Only reg_valid feeds this chain, never reg_data.
    // In lockstep mode every register follows the AND of all stage_ok, but
    // the drain chain is still built so that the commit register empties
    // during a stall instead of retiring the same instruction twice.
    // ------------------------------------------------------------------
    always_comb begin : adv_calc
        logic taken_above;
        adv         = '0;
        drain       = '0;
        taken_above = 1'b1;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            drain[i] = taken_above;
            if (GLOBAL_STALL != 0) begin
                adv[i] = all_ok;
            end else begin
                adv[i] = bus.stage_ok[i] & (~valid_q[i] | taken_above);
            end
            taken_above = adv[i];
        end
    end

    // ------------------------------------------------------------------
    // Flush range. Encodings beyond the last register mean "everything".
    // ------------------------------------------------------------------
    always_comb begin
        flush_lim = bus.flush_upto;
        if (bus.flush_upto > LAST_IDX) begin
            flush_lim = LAST_IDX;
        end
    end

    always_comb begin
        kill = '0;
        if (bus.flush_valid) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                kill[i] = (FU_W'(i) <= flush_lim);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers.
    // Priority per register: flush > load > bubble > hold. A flushed or
    // bubbled register keeps its old payload; only the valid bit drops.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (kill[i]) begin
                    valid_q[i] <= 1'b0;
                end else if (adv[i]) begin
                    valid_q[i]                  <= bus.stage_valid[i];
                    data_q[i*DATA_W +: DATA_W]  <= bus.stage_data[i*DATA_W +: DATA_W];
                end else if (drain[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Perf counters, free-running and wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_cycle  <= '0;
            cnt_commit <= '0;
            cnt_stall  <= '0;
        end else begin
            cnt_cycle <= cnt_cycle + CNT_W'(1);
            if (valid_q[NUM_STAGES-1]) begin
                cnt_commit <= cnt_commit + CNT_W'(1);
            end
            if (!all_ok) begin
                cnt_stall <= cnt_stall + CNT_W'(1);
            end
        end
    end

    // Outputs
    assign bus.reg_valid    = valid_q;
    assign bus.reg_data     = data_q;
    assign bus.stage_adv    = adv;
    assign bus.commit_valid = valid_q[NUM_STAGES-1];

endmodule

// File: tb/tb_pipe_advance_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_advance_ctrl
//   Two controllers (elastic and lockstep) share one stimulus generator that
//   behaves like the core's stage logic: stage 0 fetches instructions,
//   stage i (i >= 1) passes reg i-1 through adding i to the payload, so an
//   instruction fetched with payload P retires with P + 10. Only one
//   controller is out of reset at a time; ls selects which one is observed.
// -----------------------------------------------------------------------------
module tb_pipe_advance_ctrl;
    localparam int N    = 5;
    localparam int W    = 64;
    localparam int CW   = 6;   // narrow counters so wrap-around is exercised
    localparam int FU_W = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic ls;        // 1: lockstep instance observed
    logic cur_rst;
    assign cur_rst = ls ? rst_b : rst_a;

    // ---------------- DUTs ----------------
    pipe_advance_ctrl_if #(.NUM_STAGES(N), .DATA_W(W)) if_a ();
    pipe_advance_ctrl_if #(.NUM_STAGES(N), .DATA_W(W)) if_b ();

    logic [N-1:0]   drv_ok;
    logic [N-1:0]   drv_sv;
    logic [N*W-1:0] drv_sd;
    logic           drv_fv;
    logic [FU_W-1:0] drv_fu;

    assign if_a.stage_ok    = drv_ok;
    assign if_a.stage_valid = drv_sv;
    assign if_a.stage_data  = drv_sd;
    assign if_a.flush_valid = drv_fv;
    assign if_a.flush_upto  = drv_fu;
    assign if_b.stage_ok    = drv_ok;
    assign if_b.stage_valid = drv_sv;
    assign if_b.stage_data  = drv_sd;
    assign if_b.flush_valid = drv_fv;
    assign if_b.flush_upto  = drv_fu;

    logic [CW-1:0] cc_a, cm_a, cs_a, cc_b, cm_b, cs_b;

    pipe_advance_ctrl #(.NUM_STAGES(N), .DATA_W(W), .GLOBAL_STALL(0), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst_a), .bus(if_a.slave),
        .cnt_cycle(cc_a), .cnt_commit(cm_a), .cnt_stall(cs_a)
    );

    pipe_advance_ctrl #(.NUM_STAGES(N), .DATA_W(W), .GLOBAL_STALL(1), .CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst_b), .bus(if_b.slave),
        .cnt_cycle(cc_b), .cnt_commit(cm_b), .cnt_stall(cs_b)
    );

    // Observed outputs of the selected instance
    logic [N-1:0]   o_valid, o_adv;
    logic [N*W-1:0] o_data;
    logic           o_commit;
    logic [CW-1:0]  o_cc, o_cm, o_cs;

    always_comb begin
        if (ls) begin
            o_valid = if_b.reg_valid; o_adv = if_b.stage_adv; o_data = if_b.reg_data;
            o_commit = if_b.commit_valid; o_cc = cc_b; o_cm = cm_b; o_cs = cs_b;
        end else begin
            o_valid = if_a.reg_valid; o_adv = if_a.stage_adv; o_data = if_a.reg_data;
            o_commit = if_a.commit_valid; o_cc = cc_a; o_cm = cm_a; o_cs = cs_a;
        end
    end

    // ---------------- reference model state ----------------
    logic [N-1:0]  mv;          // which registers hold something
    logic [W-1:0]  md [N];      // payload per register
    logic [W-1:0]  mc [N];      // value the occupant will retire with
    logic [CW-1:0] m_cc, m_cm, m_cs;
    logic [W-1:0]  exp_q [$];   // retire order still owed by the pipe

    logic          pending;     // fetch has an instruction on offer
    logic [W-1:0]  pdata;
    int            seq;
    int            issued;
    int            edge_no;
    int            first_ce, last_ce;
    int            n_checks, n_errors;

    int busy_t  [12] = '{0, 20, 40, 70, 20, 0, 10, 40, 60, 30, 5, 50};
    int flush_t [12] = '{0, 0, 5, 0, 10, 0, 3, 0, 8, 15, 0, 5};
    int inj_t   [12] = '{100, 70, 100, 60, 90, 100, 80, 100, 50, 100, 100, 70};

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mv = '0;
        for (int i = 0; i < N; i++) begin
            md[i] = '0;
            mc[i] = '0;
        end
        m_cc = '0; m_cm = '0; m_cs = '0;
        exp_q.delete();
        pending = 1'b0;
        edge_no = 0;
    endtask

    task automatic drive_idle();
        drv_ok = '1; drv_sv = '0; drv_sd = '0; drv_fv = 1'b0; drv_fu = '0;
    endtask

    task automatic drop_expected(input logic [W-1:0] val);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (exp_q[k] == val) begin
                exp_q.delete(k);
                break;
            end
        end
    endtask

    // Elastic: a stage advances when it and every stage above it up to the
    // nearest empty register (or past the commit register) are ok.
    // Lockstep: everything advances only when all stages are ok.
    function automatic logic [N-1:0] ref_adv(input logic [N-1:0] ok, input logic [N-1:0] v,
                                            input logic lock);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (lock) begin
                r[i] = &ok;
            end else begin
                int hole;
                hole = i;
                while (hole < N && v[hole]) hole++;
                r[i] = 1'b1;
                for (int j = i; j <= hole && j < N; j++) r[i] = r[i] & ok[j];
            end
        end
        return r;
    endfunction

    // Model of one rising edge, using the inputs currently driven.
    task automatic model_step(input logic [N-1:0] a);
        logic [N-1:0] nv;
        logic [W-1:0] nd [N];
        logic [W-1:0] nc [N];
        int lim;
        if (mv[N-1]) m_cm = m_cm + CW'(1);
        if (!(&drv_ok)) m_cs = m_cs + CW'(1);
        m_cc = m_cc + CW'(1);
        edge_no++;
        if (a[0] && pending) begin
            exp_q.push_back(pdata + W'(10));
            pending = 1'b0;
        end
        nv = mv;
        for (int i = 0; i < N; i++) begin
            nd[i] = md[i];
            nc[i] = mc[i];
        end
        for (int i = 0; i < N; i++) begin
            logic         in_v, taken;
            logic [W-1:0] in_d, in_c;
            in_v  = (i == 0) ? drv_sv[0] : mv[i-1];
            in_d  = (i == 0) ? drv_sd[0 +: W] : md[i-1] + W'(i);
            in_c  = (i == 0) ? pdata + W'(10) : mc[i-1];
            taken = (i == N - 1) ? 1'b1 : a[i+1];
            if (a[i]) begin
                nv[i] = in_v; nd[i] = in_d; nc[i] = in_c;
            end else if (taken) begin
                nv[i] = 1'b0;
            end
        end
        if (drv_fv) begin
            lim = (int'(drv_fu) > N - 1) ? N - 1 : int'(drv_fu);
            for (int i = 0; i <= lim; i++) begin
                if (nv[i]) drop_expected(nc[i]);
                nv[i] = 1'b0;
                nd[i] = md[i];
            end
        end
        mv = nv;
        for (int i = 0; i < N; i++) begin
            md[i] = nd[i];
            mc[i] = nc[i];
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle_step(input int busy, input int flush_pct, input int inj_pct,
                              input int inj_limit);
        logic [N-1:0]   a;
        logic [N*W-1:0] mdv;
        @(negedge clk);
        for (int i = 0; i < N; i++) mdv[i*W +: W] = md[i];
        chk("reg_valid", 512'(o_valid), 512'(mv));
        chk("reg_data", 512'(o_data), 512'(mdv));
        chk("commit_valid", 512'(o_commit), 512'(mv[N-1]));
        chk("cnt_cycle", 512'(o_cc), 512'(m_cc));
        chk("cnt_commit", 512'(o_cm), 512'(m_cm));
        chk("cnt_stall", 512'(o_cs), 512'(m_cs));
        if (o_commit) begin
            if (first_ce < 0) first_ce = edge_no;
            last_ce = edge_no;
        end
        if (!pending && issued < inj_limit && int'($urandom_range(0, 99)) < inj_pct) begin
            seq++;
            issued++;
            pending = 1'b1;
            pdata   = {32'(seq), 32'($urandom)};
        end
        for (int i = 0; i < N; i++) begin
            logic v_in;
            v_in = (i == 0) ? pending : o_valid[i-1];
            drv_sv[i] = v_in;
            if (i == 0) drv_sd[0 +: W] = pending ? pdata : {32'($urandom), 32'($urandom)};
            else        drv_sd[i*W +: W] = o_data[(i-1)*W +: W] + W'(i);
            drv_ok[i] = v_in ? (int'($urandom_range(0, 99)) >= busy) : 1'b1;
        end
        drv_fv = (int'($urandom_range(0, 99)) < flush_pct);
        drv_fu = FU_W'($urandom_range(0, 7));
        #1;
        a = ref_adv(drv_ok, mv, ls);
        chk("stage_adv", 512'(o_adv), 512'(a));
        @(posedge clk);
        model_step(a);
    endtask

    // Switch observed instance; both held in reset, then release one.
    task automatic enter_mode(input logic lock);
        @(negedge clk); #2;
        rst_a = 1'b0; rst_b = 1'b0; ls = lock;
        drive_idle();
        model_clear();
        @(posedge clk); #1;
        if (lock) rst_b = 1'b1; else rst_a = 1'b1;
    endtask

    // Asynchronous reset in the middle of traffic.
    task automatic do_reset();
        @(negedge clk); #2;
        if (ls) rst_b = 1'b0; else rst_a = 1'b0;
        #1;
        chk("rst_reg_valid", 512'(o_valid), 512'(0));
        chk("rst_reg_data", 512'(o_data), 512'(0));
        chk("rst_commit", 512'(o_commit), 512'(0));
        chk("rst_cnt_cycle", 512'(o_cc), 512'(0));
        chk("rst_cnt_commit", 512'(o_cm), 512'(0));
        chk("rst_cnt_stall", 512'(o_cs), 512'(0));
        drive_idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        if (ls) rst_b = 1'b1; else rst_a = 1'b1;
    endtask

    // ---------------- monitor: retire order ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (cur_rst && o_commit) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL commit_unexpected: got %0h expected none", o_data[(N-1)*W +: W]);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_data", 512'(o_data[(N-1)*W +: W]), 512'(e));
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0; n_errors = 0; seq = 0; issued = 0;
        first_ce = -1; last_ce = -1;
        ls = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
        drive_idle();
        model_clear();
        repeat (3) @(posedge clk);

        for (int m = 0; m < 2; m++) begin
            enter_mode(m == 1);

            // Ten back-to-back instructions, all stages ready.
            first_ce = -1; last_ce = -1; issued = 0;
            repeat (25) cycle_step(0, 0, 100, 10);
            chk("lat_first_commit_edge", 512'(first_ce), 512'(5));
            chk("lat_last_commit_edge", 512'(last_ce), 512'(14));
            chk("ten_commits", 512'(o_cm), 512'(10));

            for (int s = 0; s < 12; s++) begin
                issued = 0;
                repeat (150) cycle_step(busy_t[s], flush_t[s], inj_t[s], 1 << 30);
                if (s == 5) do_reset();
            end

            // Drain and confirm nothing was lost.
            issued = 0;
            repeat (30) cycle_step(0, 0, 0, 0);
            chk("drained_queue", 512'(exp_q.size()), 512'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
